// File: rtl/enigma_step_ctrl.sv
// ---------------------------------------------------------------------------
// enigma_step_ctrl
//   Sequencer for a three-rotor Enigma datapath. Takes one plaintext letter
//   per key handshake, advances the rotor positions like an odometer with
//   notch carries, clocks the external rotor chain with a strobe train, and
//   presents the chain's result on an out_valid/out_ready handshake. In set
//   mode (mode=1, idle) the rotor positions can be loaded directly.
//
//   Optional feature: define DOUBLE_STEP_EN for the historical double step
//   (rotor 1 also advances whenever it sits on its own notch).
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   mode       0 = encrypt, 1 = set positions
//   key_valid  letter offered          key_in   letter 1..26 (A=1)
//   key_ready  controller can accept a letter
//   set_we     set-mode write strobe   set_sel  rotor 0..2 (3 = no-op)
//   set_val    new position 1..26
//   rot_in     letter driven to the rotor chain
//   rot_cnt0/1/2  rotor positions, zero-extended to 6 bits
//   rot_strobe pulse train clocking the rotor chain
//   rot_out    result of the rotor chain
//   out_valid  ciphertext valid        out_char ciphertext letter
//   out_ready  consumer accepts out_char
//   err        one-cycle pulse on a bad key or bad set value
// ---------------------------------------------------------------------------
module enigma_step_ctrl #(
    parameter int NOTCH0    = 17,
    parameter int NOTCH1    = 5,
    parameter int ROTOR_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       key_valid,
    input  logic [4:0] key_in,
    output logic       key_ready,
    input  logic       set_we,
    input  logic [1:0] set_sel,
    input  logic [4:0] set_val,
    output logic [4:0] rot_in,
    output logic [5:0] rot_cnt0,
    output logic [5:0] rot_cnt1,
    output logic [5:0] rot_cnt2,
    output logic       rot_strobe,
    input  logic [4:0] rot_out,
    output logic       out_valid,
    output logic [4:0] out_char,
    input  logic       out_ready,
    output logic       err
);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_ENC, S_DONE} state_t;

    localparam int             KW     = (2 * ROTOR_LAT > 2) ? $clog2(2 * ROTOR_LAT) : 1;
    localparam logic [KW-1:0]  K_LAST = KW'(2 * ROTOR_LAT - 1);
    localparam logic [4:0]     N0     = 5'(NOTCH0);
    localparam logic [4:0]     N1     = 5'(NOTCH1);

    // Positions live in 1..26; 26 wraps back to 1, never to 0.
    function automatic logic [4:0] pos_inc(input logic [4:0] p);
        return (p == 5'd26) ? 5'd1 : p + 5'd1;
    endfunction

    function automatic logic letter_ok(input logic [4:0] v);
        return (v >= 5'd1) && (v <= 5'd26);
    endfunction

    state_t        r_state;
    logic [4:0]    r_pos0, r_pos1, r_pos2;
    logic [KW-1:0] r_k;
    logic          r_key_ready;
    logic [4:0]    r_rot_in;
    logic          r_strobe;
    logic          r_out_valid;
    logic [4:0]    r_out_char;
    logic          r_err;

    logic w_c1, w_c2, w_adv1;

    // Carries are judged on the positions before this step.
    assign w_c1 = (r_pos0 == N0);
    assign w_c2 = (r_pos1 == N1);

`ifdef DOUBLE_STEP_EN
    // Rotor 1 sitting on its notch drags itself along with rotor 2;
    // it still advances only once if rotor 0 carries at the same time.
    assign w_adv1 = w_c1 | w_c2;
`else
    assign w_adv1 = w_c1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pos0      <= 5'd1;
            r_pos1      <= 5'd1;
            r_pos2      <= 5'd1;
            r_k         <= '0;
            r_key_ready <= 1'b0;
            r_rot_in    <= 5'd0;
            r_strobe    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_char  <= 5'd0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // key_ready is registered, so it follows mode one cycle late.
                    r_key_ready <= !mode;
                    if (key_valid && r_key_ready) begin
                        if (letter_ok(key_in)) begin
                            r_rot_in    <= key_in;
                            r_key_ready <= 1'b0;
                            r_state     <= S_STEP;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    if (mode && set_we) begin
                        if (!letter_ok(set_val)) begin
                            r_err <= 1'b1;
                        end else begin
                            case (set_sel)
                                2'd0:    r_pos0 <= set_val;
                                2'd1:    r_pos1 <= set_val;
                                2'd2:    r_pos2 <= set_val;
                                default: ;
                            endcase
                        end
                    end
                end
                S_STEP: begin
                    r_pos0 <= pos_inc(r_pos0);
                    if (w_adv1) r_pos1 <= pos_inc(r_pos1);
                    if (w_c2)   r_pos2 <= pos_inc(r_pos2);
                    r_k      <= '0;
                    r_strobe <= 1'b1;
                    r_state  <= S_ENC;
                end
                S_ENC: begin
                    if (r_k == K_LAST) begin
                        r_strobe    <= 1'b0;
                        r_out_char  <= rot_out;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_k      <= r_k + 1'b1;
                        // Strobe high on even k: next index is even when current is odd.
                        r_strobe <= r_k[0];
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_key_ready <= !mode;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign key_ready  = r_key_ready;
    assign rot_in     = r_rot_in;
    assign rot_cnt0   = {1'b0, r_pos0};
    assign rot_cnt1   = {1'b0, r_pos1};
    assign rot_cnt2   = {1'b0, r_pos2};
    assign rot_strobe = r_strobe;
    assign out_valid  = r_out_valid;
    assign out_char   = r_out_char;
    assign err        = r_err;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_enigma_step_ctrl
//   Directed plus randomized bench for enigma_step_ctrl. Rotor positions are
//   tracked as plain integers and advanced by the stepping rules; the rotor
//   chain is stood in for by a random rot_out that changes every cycle, with
//   a history kept so the expected ciphertext is the value present on the
//   last encryption cycle.
// ---------------------------------------------------------------------------
module tb_enigma_step_ctrl;

`ifdef DOUBLE_STEP_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    localparam int L = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       key_valid;
    logic [4:0] key_in;
    logic       key_ready;
    logic       set_we;
    logic [1:0] set_sel;
    logic [4:0] set_val;
    logic [4:0] rot_in;
    logic [5:0] rot_cnt0, rot_cnt1, rot_cnt2;
    logic       rot_strobe;
    logic [4:0] rot_out;
    logic       out_valid;
    logic [4:0] out_char;
    logic       out_ready;
    logic       err;

    enigma_step_ctrl #(.NOTCH0(17), .NOTCH1(5), .ROTOR_LAT(L)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
        .set_we(set_we), .set_sel(set_sel), .set_val(set_val),
        .rot_in(rot_in), .rot_cnt0(rot_cnt0), .rot_cnt1(rot_cnt1), .rot_cnt2(rot_cnt2),
        .rot_strobe(rot_strobe), .rot_out(rot_out),
        .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int m0, m1, m2;
    logic [4:0] rot_hist [0:8191];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rot_out = 5'($urandom);
        if (cyc < 8192) rot_hist[cyc] = rot_out;
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_p0"}, 32'(rot_cnt0), 32'(m0));
        check({tag, "_p1"}, 32'(rot_cnt1), 32'(m1));
        check({tag, "_p2"}, 32'(rot_cnt2), 32'(m2));
    endtask

    function automatic int wrap_inc(input int p);
        return (p % 26) + 1;
    endfunction

    // Odometer: rotor 0 always moves; a rotor leaving its notch carries the next.
    task automatic model_step();
        bit c1, c2;
        c1 = (m0 == 17);
        c2 = (m1 == 5);
        m0 = wrap_inc(m0);
        if (c1 || (DS && c2)) m1 = wrap_inc(m1);
        if (c2) m2 = wrap_inc(m2);
    endtask

    task automatic set_one(input int sel, input int val);
        bit bad;
        bad = (val < 1) || (val > 26);
        set_we = 1'b1; set_sel = 2'(sel); set_val = 5'(val);
        tick();
        set_we = 1'b0;
        check("set_err", 32'(err), 32'(bad));
        if (!bad) begin
            if (sel == 0) m0 = val;
            else if (sel == 1) m1 = val;
            else if (sel == 2) m2 = val;
        end
        tick();
        check("set_err_clr", 32'(err), 0);
        check_pos("set");
    endtask

    task automatic set_positions(input int a, input int b, input int c);
        mode = 1'b1;
        tick();
        check("set_mode_kr", 32'(key_ready), 0);
        set_one(0, a);
        set_one(1, b);
        set_one(2, c);
        mode = 1'b0;
        tick();
    endtask

    task automatic encrypt(input int k, input int hold);
        int n, e;
        logic [4:0] exp_c;
        n = 0;
        while (key_ready !== 1'b1 && n < 20) begin tick(); n++; end
        check("wait_key_ready", 32'(key_ready), 1);
        check("pre_ov", 32'(out_valid), 0);
        key_valid = 1'b1; key_in = 5'(k);
        tick();
        key_valid = 1'b0;
        e = cyc;
        check("step_kr", 32'(key_ready), 0);
        check("step_rot_in", 32'(rot_in), 32'(k));
        model_step();
        for (int j = 0; j < 2 * L; j++) begin
            tick();
            check("enc_strobe", 32'(rot_strobe), 32'((j % 2) == 0));
            check("enc_rot_in", 32'(rot_in), 32'(k));
            check("enc_ov", 32'(out_valid), 0);
            check_pos("enc");
        end
        tick();
        exp_c = rot_hist[e + 2 * L];
        check("done_latency", 32'(cyc - e + 1), 32'(2 + 2 * L));
        check("done_ov", 32'(out_valid), 1);
        check("done_char", 32'(out_char), 32'(exp_c));
        check("done_strobe", 32'(rot_strobe), 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_ov", 32'(out_valid), 1);
            check("hold_char", 32'(out_char), 32'(exp_c));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rel_ov", 32'(out_valid), 0);
        check("rel_kr", 32'(key_ready), 1);
    endtask

    task automatic bad_key(input int k);
        key_valid = 1'b1; key_in = 5'(k);
        tick();
        key_valid = 1'b0;
        check("badkey_err", 32'(err), 1);
        check("badkey_kr", 32'(key_ready), 1);
        tick();
        check("badkey_err_clr", 32'(err), 0);
        check("badkey_strobe", 32'(rot_strobe), 0);
        check_pos("badkey");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mode = 1'b0; key_valid = 1'b0; key_in = 5'd0;
        set_we = 1'b0; set_sel = 2'd0; set_val = 5'd0; out_ready = 1'b0;
        rot_out = 5'd0; rot_hist[0] = 5'd0;
        m0 = 1; m1 = 1; m2 = 1;
        #2;
        check("rst_kr", 32'(key_ready), 0);
        check("rst_ov", 32'(out_valid), 0);
        check("rst_char", 32'(out_char), 0);
        check("rst_rot_in", 32'(rot_in), 0);
        check("rst_strobe", 32'(rot_strobe), 0);
        check("rst_err", 32'(err), 0);
        check_pos("rst");
        tick(); tick();
        rst = 1'b0;
        tick();
        check("idle_kr", 32'(key_ready), 1);

        // first letter from home position
        encrypt(1, 0);
        check("t2_p0", 32'(rot_cnt0), 2);
        check("t2_p1", 32'(rot_cnt1), 1);

        // notch carry and wrap cases
        set_positions(17, 1, 1);
        encrypt(5, 1);
        check("t3_p0", 32'(rot_cnt0), 18);
        check("t3_p1", 32'(rot_cnt1), 2);
        set_positions(17, 26, 26);
        encrypt(3, 0);
        check("t3w_p1", 32'(rot_cnt1), 1);
        check("t3w_p2", 32'(rot_cnt2), 26);
        set_positions(26, 5, 26);
        encrypt(26, 0);
        check("t3w_p0", 32'(rot_cnt0), 1);
        check("t3w2_p2", 32'(rot_cnt2), 1);

        // rotor 1 on its notch
        set_positions(1, 5, 7);
        encrypt(12, 2);
        check("t4_p0", 32'(rot_cnt0), 2);
        check("t4_p1", 32'(rot_cnt1), DS ? 6 : 5);
        check("t4_p2", 32'(rot_cnt2), 8);

        // set mode writes and rejects
        mode = 1'b1;
        tick();
        check("t5_kr", 32'(key_ready), 0);
        set_one(1, 9);
        check("t5_p1", 32'(rot_cnt1), 9);
        set_one(0, 0);
        set_one(2, 27);
        set_one(3, 4);
        mode = 1'b0;
        tick();

        // long back-pressure, then bad keys in idle
        encrypt(20, 5);
        bad_key(0);
        bad_key(27);
        bad_key(31);

        // randomized letters and positions, biased towards the notches
        for (int r = 0; r < 8; r++) begin
            int a, b, c;
            a = ($urandom_range(0, 2) == 0) ? 17 : $urandom_range(1, 26);
            b = ($urandom_range(0, 2) == 0) ? 5  : $urandom_range(1, 26);
            c = $urandom_range(1, 26);
            if (r % 2 == 0) set_positions(a, b, c);
            encrypt($urandom_range(1, 26), $urandom_range(0, 3));
        end

        // reset in the middle of the strobe train
        key_valid = 1'b1; key_in = 5'd4;
        tick();
        key_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        m0 = 1; m1 = 1; m2 = 1;
        check("mrst_kr", 32'(key_ready), 0);
        check("mrst_strobe", 32'(rot_strobe), 0);
        check("mrst_rot_in", 32'(rot_in), 0);
        check("mrst_ov", 32'(out_valid), 0);
        check("mrst_char", 32'(out_char), 0);
        check("mrst_err", 32'(err), 0);
        check_pos("mrst");
        tick();
        rst = 1'b0;
        tick();
        check("mrst_idle_kr", 32'(key_ready), 1);
        check("mrst_idle_strobe", 32'(rot_strobe), 0);
        encrypt(7, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
